// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the gate bank response checker: FSM states,
// fail_mask bit positions and the size of the exhaustive input sweep.
package gate_response_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int NUM_GATES   = 7;

    localparam int MSK_NOT  = 0;
    localparam int MSK_AND  = 1;
    localparam int MSK_NAND = 2;
    localparam int MSK_OR   = 3;
    localparam int MSK_NOR  = 4;
    localparam int MSK_XOR  = 5;
    localparam int MSK_XNOR = 6;

endpackage

// File: rtl/gate_response_checker_expect.sv
// Truth table of the two-input gate bank: maps the driven {a,b} to the
// seven outputs a healthy bank must return, in fail_mask bit order.
module gate_expect
    import gate_response_checker_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] exp_vec
);

    always_comb begin
        exp_vec           = '0;
        exp_vec[MSK_NOT]  = ~a;
        exp_vec[MSK_AND]  = a & b;
        exp_vec[MSK_NAND] = ~(a & b);
        exp_vec[MSK_OR]   = a | b;
        exp_vec[MSK_NOR]  = ~(a | b);
        exp_vec[MSK_XOR]  = a ^ b;
        exp_vec[MSK_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_response_checker.sv
// Drives the gate bank through {a,b} = 00,01,10,11, lets each vector settle,
// then compares the seven returned outputs and accumulates pass/fail status.
module gate_response_checker
    import gate_response_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   a_out,
    output logic                   b_out,
    input  logic                   not_in,
    input  logic                   and_in,
    input  logic                   nand_in,
    input  logic                   or_in,
    input  logic                   nor_in,
    input  logic                   xor_in,
    input  logic                   xnor_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [NUM_VECTORS-1:0] fail_vec,
    output logic [NUM_GATES-1:0]   fail_mask
);

    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_VECTORS);

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_VECTORS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    state_t                 state_q, state_nxt;
    logic [CNT_W-1:0]       settle_cnt_q, settle_cnt_nxt;
    logic [IDX_W-1:0]       vec_idx_q, vec_idx_nxt;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_nxt;
    logic [NUM_VECTORS-1:0] fail_vec_q, fail_vec_nxt;
    logic [NUM_GATES-1:0]   fail_mask_q, fail_mask_nxt;
    logic                   pass_q, pass_nxt;

    logic [NUM_GATES-1:0]   rx_vec;
    logic [NUM_GATES-1:0]   exp_vec;
    logic [NUM_GATES-1:0]   mismatch;

    // The vector index doubles as the driven {a,b} pair.
    gate_expect u_expect (
        .a       (vec_idx_q[1]),
        .b       (vec_idx_q[0]),
        .exp_vec (exp_vec)
    );

    always_comb begin
        rx_vec           = '0;
        rx_vec[MSK_NOT]  = not_in;
        rx_vec[MSK_AND]  = and_in;
        rx_vec[MSK_NAND] = nand_in;
        rx_vec[MSK_OR]   = or_in;
        rx_vec[MSK_NOR]  = nor_in;
        rx_vec[MSK_XOR]  = xor_in;
        rx_vec[MSK_XNOR] = xnor_in;
    end

    assign mismatch = rx_vec ^ exp_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            vec_idx_q    <= '0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            fail_mask_q  <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            settle_cnt_q <= settle_cnt_nxt;
            vec_idx_q    <= vec_idx_nxt;
            err_cnt_q    <= err_cnt_nxt;
            fail_vec_q   <= fail_vec_nxt;
            fail_mask_q  <= fail_mask_nxt;
            pass_q       <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        settle_cnt_nxt = settle_cnt_q;
        vec_idx_nxt    = vec_idx_q;
        err_cnt_nxt    = err_cnt_q;
        fail_vec_nxt   = fail_vec_q;
        fail_mask_nxt  = fail_mask_q;
        pass_nxt       = pass_q;
        busy           = 1'b1;
        done           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt      = ST_SETTLE;
                    settle_cnt_nxt = '0;
                    vec_idx_nxt    = '0;
                    err_cnt_nxt    = '0;
                    fail_vec_nxt   = '0;
                    fail_mask_nxt  = '0;
                    pass_nxt       = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_q == CNT_LAST) begin
                    state_nxt      = ST_CHECK;
                    settle_cnt_nxt = '0;
                end else begin
                    settle_cnt_nxt = settle_cnt_q + 1'b1;
                end
            end

            ST_CHECK: begin
                fail_mask_nxt = fail_mask_q | mismatch;
                if (|mismatch) begin
                    fail_vec_nxt[vec_idx_q] = 1'b1;
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_nxt = err_cnt_q + 1'b1;
                    end
                end
                // Clearing the index on the last vector parks a/b at 00 for DONE.
                if (vec_idx_q == IDX_LAST) begin
                    state_nxt   = ST_DONE;
                    vec_idx_nxt = '0;
                    pass_nxt    = (fail_vec_nxt == '0);
                end else begin
                    state_nxt      = ST_SETTLE;
                    vec_idx_nxt    = vec_idx_q + 1'b1;
                    settle_cnt_nxt = '0;
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign a_out     = vec_idx_q[1];
    assign b_out     = vec_idx_q[0];
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a faultable gate bank model drives two
// checker instances; a closed-form run model is compared every cycle.
module tb_gate_response_checker;

    localparam int MS = 2;
    localparam int MW = 4;
    localparam int SS = 1;
    localparam int SW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0][6:0] flips = '0;

    logic m_a, m_b, m_busy, m_done, m_pass;
    logic [3:0] m_err;
    logic [3:0] m_fv;
    logic [6:0] m_fm;
    logic [6:0] m_bank;

    logic s_a, s_b, s_busy, s_done, s_pass;
    logic [0:0] s_err;
    logic [3:0] s_fv;
    logic [6:0] s_fm;
    logic [6:0] s_bank;

    int n_checks = 0;
    int n_pass = 0;

    bit tm_act = 0, tm_hr = 0;
    int tm_n = 0;
    logic [3:0][6:0] tm_fl = '0;
    bit ts_act = 0, ts_hr = 0;
    int ts_n = 0;
    logic [3:0][6:0] ts_fl = '0;

    initial forever #5 clk = ~clk;

    function automatic logic [6:0] truth(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b, ~a};
    endfunction

    function automatic logic [6:0] bank_out(input logic a, input logic b, input logic [3:0][6:0] fl);
        return truth(a, b) ^ fl[{a, b}];
    endfunction

    assign m_bank = bank_out(m_a, m_b, flips);
    assign s_bank = bank_out(s_a, s_b, flips);

    gate_response_checker #(.SETTLE_CYCLES(MS), .ERR_CNT_W(MW)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(m_a), .b_out(m_b),
        .not_in(m_bank[0]), .and_in(m_bank[1]), .nand_in(m_bank[2]), .or_in(m_bank[3]),
        .nor_in(m_bank[4]), .xor_in(m_bank[5]), .xnor_in(m_bank[6]),
        .busy(m_busy), .done(m_done), .pass(m_pass), .err_cnt(m_err),
        .fail_vec(m_fv), .fail_mask(m_fm)
    );

    gate_response_checker #(.SETTLE_CYCLES(SS), .ERR_CNT_W(SW)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(s_a), .b_out(s_b),
        .not_in(s_bank[0]), .and_in(s_bank[1]), .nand_in(s_bank[2]), .or_in(s_bank[3]),
        .nor_in(s_bank[4]), .xor_in(s_bank[5]), .xnor_in(s_bank[6]),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
        .fail_vec(s_fv), .fail_mask(s_fm)
    );

    // Expected outputs n edges after the start-accept edge, from the run rules:
    // vector v is driven for S+1 cycles, its result lands at edge (v+1)(S+1).
    function automatic logic [19:0] model_out(input bit act, input int n, input bit hr,
                                              input logic [3:0][6:0] fl, input int s, input int w);
        int comp, cnt, errmax;
        logic [1:0] ab;
        logic [3:0] fv;
        logic [6:0] fm;
        bit bsy, dn, ps;
        ab = 2'b00; dn = 0; bsy = act;
        if (act) begin
            if (n < 4 * (s + 1)) begin
                comp = n / (s + 1);
                ab = 2'(comp);
            end else begin
                comp = 4;
                dn = 1;
            end
        end else begin
            comp = hr ? 4 : 0;
        end
        fv = '0; fm = '0; cnt = 0;
        for (int v = 0; v < comp; v++) begin
            if (fl[v] != 7'h00) begin
                fv[v] = 1'b1;
                cnt++;
            end
            fm = fm | fl[v];
        end
        errmax = (1 << w) - 1;
        ps = (comp == 4) && (fv == 4'b0000);
        return {fm, fv, 4'(cnt > errmax ? errmax : cnt), ps, dn, bsy, ab};
    endfunction

    function automatic logic [19:0] pack_main();
        return {m_fm, m_fv, m_err, m_pass, m_done, m_busy, m_a, m_b};
    endfunction

    function automatic logic [19:0] pack_sat();
        return {s_fm, s_fv, 3'b000, s_err, s_pass, s_done, s_busy, s_a, s_b};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_act <= 0; tm_hr <= 0; tm_n <= 0;
        end else if (tm_act) begin
            if (tm_n == 4 * (MS + 1)) begin
                tm_act <= 0; tm_hr <= 1;
            end
            tm_n <= tm_n + 1;
        end else if (start) begin
            tm_act <= 1; tm_n <= 0; tm_fl <= flips;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_act <= 0; ts_hr <= 0; ts_n <= 0;
        end else if (ts_act) begin
            if (ts_n == 4 * (SS + 1)) begin
                ts_act <= 0; ts_hr <= 1;
            end
            ts_n <= ts_n + 1;
        end else if (start) begin
            ts_act <= 1; ts_n <= 0; ts_fl <= flips;
        end
    end

    always @(negedge clk) begin
        check("cycle_main", 32'(pack_main()), 32'(model_out(tm_act, tm_n, tm_hr, tm_fl, MS, MW)));
        check("cycle_sat", 32'(pack_sat()), 32'(model_out(ts_act, ts_n, ts_hr, ts_fl, SS, SW)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (!m_busy && !s_busy) ok = 1;
            else tick();
        end
        check("idle_wait", 32'(ok), 32'd1);
    endtask

    task automatic do_run(input string nm, input logic [3:0][6:0] fl, input bit mid,
                          input logic mp, input logic [3:0] me, input logic [3:0] mfv,
                          input logic [6:0] mfm, input logic sp, input logic se);
        int edges, s_edges;
        bit mgot, sgot;
        logic [19:0] mcap, scap;
        wait_idle();
        flips = fl;
        start = 1'b1;
        edges = 0; s_edges = 0; mgot = 0; sgot = 0; mcap = '0; scap = '0;
        for (int i = 0; i < 40 && !mgot; i++) begin
            tick();
            edges++;
            start = mid && (edges == 1);
            if (s_done && !sgot) begin
                sgot = 1; s_edges = edges; scap = pack_sat();
            end
            if (m_done) begin
                mgot = 1; mcap = pack_main();
            end
        end
        check({nm, "_main_latency"}, 32'(edges), 32'd13);
        check({nm, "_sat_latency"}, 32'(s_edges), 32'd9);
        check({nm, "_main_pass"}, 32'(mcap[4]), 32'(mp));
        check({nm, "_main_err"}, 32'(mcap[8:5]), 32'(me));
        check({nm, "_main_fail_vec"}, 32'(mcap[12:9]), 32'(mfv));
        check({nm, "_main_fail_mask"}, 32'(mcap[19:13]), 32'(mfm));
        check({nm, "_sat_pass"}, 32'(scap[4]), 32'(sp));
        check({nm, "_sat_err"}, 32'(scap[8:5]), 32'(se));
        check({nm, "_sat_fail_vec"}, 32'(scap[12:9]), 32'(mfv));
        tick();
        check({nm, "_main_held"}, 32'(pack_main()), 32'({mfm, mfv, me, mp, 1'b0, 1'b0, 2'b00}));
    endtask

    initial begin
        logic [3:0][6:0] f;
        int busy_cnt, done_cnt;
        bit found;

        repeat (3) tick();
        check("rst_main", 32'(pack_main()), 32'd0);
        check("rst_sat", 32'(pack_sat()), 32'd0);
        rst_n = 1'b1;
        tick();

        f = '0;
        do_run("ok", f, 0, 1'b1, 4'd0, 4'b0000, 7'h00, 1'b1, 1'b0);

        f = '0; f[1] = 7'h20; f[2] = 7'h20;
        do_run("xor0", f, 0, 1'b0, 4'd2, 4'b0110, 7'h20, 1'b0, 1'b1);

        f = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
        do_run("inv", f, 0, 1'b0, 4'd4, 4'b1111, 7'h7F, 1'b0, 1'b1);

        f = '0; f[0] = 7'h02; f[1] = 7'h02; f[2] = 7'h02;
        do_run("and1", f, 0, 1'b0, 4'd3, 4'b0111, 7'h02, 1'b0, 1'b1);
        f = '0;
        do_run("ok_after_fail", f, 1, 1'b1, 4'd0, 4'b0000, 7'h00, 1'b1, 1'b0);

        // start held high across a whole run
        wait_idle();
        start = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i <= 13 && m_busy) busy_cnt++;
            if (m_done) done_cnt++;
            if (i == 14) check("held_back_to_idle", 32'(m_busy), 32'd0);
        end
        check("held_one_done", 32'(done_cnt), 32'd1);
        check("held_busy", 32'(busy_cnt), 32'd13);
        tick();
        check("held_restart", 32'(m_busy), 32'd1);
        start = 1'b0;
        wait_idle();

        // asynchronous reset while vector 10 is driven
        flips = '0;
        start = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            start = 1'b0;
            if (m_a && !m_b) found = 1;
        end
        check("reach_vec10", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_main", 32'(pack_main()), 32'd0);
        check("async_rst_sat", 32'(pack_sat()), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        f = '0;
        do_run("after_rst", f, 0, 1'b1, 4'd0, 4'b0000, 7'h00, 1'b1, 1'b0);

        // randomized faults and start activity, checked by the per-cycle model
        for (int r = 0; r < 25; r++) begin
            wait_idle();
            for (int v = 0; v < 4; v++) flips[v] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            for (int k = 0; k < 20 + int'($urandom_range(0, 20)); k++) begin
                start = ($urandom_range(0, 3) == 0);
                tick();
            end
            start = 1'b0;
        end
        wait_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
